// File: rtl/sync_gray_nff.sv
// sync_gray_nff: multi-stage gray pointer synchronizer with binary decode, advance, change strobe and sticky error
module sync_gray_nff #(
    parameter int PTRSIZE = 10,
    parameter int STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PTRSIZE:0] gin,
    input  logic             err_clr,
    output logic [PTRSIZE:0] gout,
    output logic [PTRSIZE:0] bout,
    output logic [PTRSIZE:0] delta,
    output logic             changed,
    output logic             err
);
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("sync_gray_nff: STAGES must be in 2..4");
    end

    logic [PTRSIZE:0] s [STAGES];
    logic [PTRSIZE:0] gprev;
    logic [PTRSIZE:0] bnext;
    logic [PTRSIZE:0] diff;
    logic             err_set;

    assign gout = s[STAGES-1];

    // synchronizer chain, shifts every edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) s[k] <= '0;
        end else begin
            s[0] <= gin;
            for (int k = 1; k < STAGES; k++) s[k] <= s[k-1];
        end
    end

    // gray decode as prefix xor from the msb, and multi-bit change detect
    always_comb begin
        for (int i = 0; i <= PTRSIZE; i++) bnext[i] = ^(gout >> i);
        diff    = gout ^ gprev;
        err_set = (diff & (diff - 1'b1)) != '0;
    end

    // registered post stage; err set dominates clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gprev   <= '0;
            bout    <= '0;
            delta   <= '0;
            changed <= 1'b0;
            err     <= 1'b0;
        end else begin
            gprev   <= gout;
            bout    <= bnext;
            delta   <= bnext - bout;
            changed <= diff != '0;
            err     <= err_set | (err & ~err_clr);
        end
    end
endmodule
